// File: rtl/sample_tx.sv
// Serializes captured sample words (or a fixed ID reply) LSB-first into a byte-wide UART handshake.
// Latency 1 from word/ID load to first tx_stb_o; XON/XOFF pause applies only at byte boundaries.
module sample_tx #(
  parameter logic [31:0] ID_WORD = 32'h534C4131
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [31:0] smpl_i,
  input  logic        smpl_stb_i,
  output logic        smpl_rdy_o,
  input  logic [3:0]  grp_en_i,
  input  logic        id_stb_i,
  input  logic        xon_i,
  input  logic        xoff_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_stb_o,
  input  logic        tx_rdy_i,
  output logic        busy_o,
  output logic        xoff_o
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_shift, w_shift_nx;
  logic [3:0]  r_mask, w_mask_nx, w_low, w_mask_left;
  logic        r_pause, w_pause_nx;
  logic        r_id_pend, w_id_pend_nx;
  logic        r_held, w_held_nx;
  logic        w_stb, w_xfer, w_id_req;
  logic [7:0]  w_byte;

  // One-hot lowest pending byte; this is the byte on the wire.
  assign w_low       = r_mask & (~r_mask + 4'd1);
  assign w_mask_left = r_mask & ~w_low;

  always_comb begin
    w_byte = 8'h00;
    if (w_low[0])      w_byte = r_shift[7:0];
    else if (w_low[1]) w_byte = r_shift[15:8];
    else if (w_low[2]) w_byte = r_shift[23:16];
    else if (w_low[3]) w_byte = r_shift[31:24];
  end

  // r_held keeps an already-offered byte on the wire through a pause.
  assign w_stb    = (r_state == ST_SEND) && (r_mask != 4'd0) && (r_held || !r_pause);
  assign w_xfer   = w_stb && tx_rdy_i;
  assign w_id_req = id_stb_i || r_id_pend;

  assign smpl_rdy_o = (r_state == ST_IDLE) && !w_id_req;
  assign tx_stb_o   = w_stb;
  assign tx_data_o  = w_stb ? w_byte : 8'h00;
  assign busy_o     = (r_state == ST_SEND);
  assign xoff_o     = r_pause;

  always_comb begin
    w_state_nx   = r_state;
    w_shift_nx   = r_shift;
    w_mask_nx    = r_mask;
    w_id_pend_nx = r_id_pend | id_stb_i;
    w_held_nx    = w_stb && !tx_rdy_i;
    w_pause_nx   = xoff_i ? 1'b1 : (xon_i ? 1'b0 : r_pause);

    case (r_state)
      ST_IDLE: begin
        if (w_id_req) begin
          w_shift_nx   = ID_WORD;
          w_mask_nx    = 4'hF;
          w_id_pend_nx = 1'b0;
          w_state_nx   = ST_SEND;
        end else if (smpl_stb_i && (grp_en_i != 4'd0)) begin
          w_shift_nx = smpl_i;
          w_mask_nx  = grp_en_i;
          w_state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          w_mask_nx = w_mask_left;
          if (w_mask_left == 4'd0) begin
            // A queued ID reply follows the last byte with no idle bubble.
            if (w_id_req) begin
              w_shift_nx   = ID_WORD;
              w_mask_nx    = 4'hF;
              w_id_pend_nx = 1'b0;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= ST_IDLE;
      r_shift   <= 32'd0;
      r_mask    <= 4'd0;
      r_pause   <= 1'b0;
      r_id_pend <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_shift   <= w_shift_nx;
      r_mask    <= w_mask_nx;
      r_pause   <= w_pause_nx;
      r_id_pend <= w_id_pend_nx;
      r_held    <= w_held_nx;
    end
  end

endmodule

// File: tb/tb_sample_tx.sv
// Scoreboard bench for sample_tx: expected bytes queued at stimulus, popped on each UART transfer.
module tb_sample_tx;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [31:0] smpl_i;
  logic        smpl_stb_i;
  logic        smpl_rdy_o;
  logic [3:0]  grp_en_i;
  logic        id_stb_i, xon_i, xoff_i;
  logic [7:0]  tx_data_o;
  logic        tx_stb_o;
  logic        tx_rdy_i;
  logic        busy_o, xoff_o;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  exp_b;

  always #5 clk_i = ~clk_i;

  sample_tx dut (
    .clk_i(clk_i), .rst_in(rst_in), .smpl_i(smpl_i), .smpl_stb_i(smpl_stb_i),
    .smpl_rdy_o(smpl_rdy_o), .grp_en_i(grp_en_i), .id_stb_i(id_stb_i),
    .xon_i(xon_i), .xoff_i(xoff_i), .tx_data_o(tx_data_o), .tx_stb_o(tx_stb_o),
    .tx_rdy_i(tx_rdy_i), .busy_o(busy_o), .xoff_o(xoff_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk_i) begin
    if (rst_in && tx_stb_o && tx_rdy_i) begin
      chk("sb_has_entry", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        chk("tx_byte", tx_data_o, exp_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] g);
    smpl_i     = w;
    grp_en_i   = g;
    smpl_stb_i = 1'b1;
    for (int k = 0; k < 4; k++)
      if (g[k]) sb_q.push_back(w[8*k +: 8]);
    @(negedge clk_i);
    chk("smpl_rdy_at_xfer", smpl_rdy_o, 1);
    tick();
    smpl_stb_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy_o, 0);
  endtask

  task automatic push_id();
    sb_q.push_back(8'h31);
    sb_q.push_back(8'h41);
    sb_q.push_back(8'h4C);
    sb_q.push_back(8'h53);
  endtask

  int n, cnt;

  initial begin
    rst_in = 1'b0; smpl_i = '0; smpl_stb_i = 0; grp_en_i = '0;
    id_stb_i = 0; xon_i = 0; xoff_i = 0; tx_rdy_i = 1'b1;
    #1;
    chk("rst_smpl_rdy", smpl_rdy_o, 1);
    chk("rst_tx_stb", tx_stb_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_xoff", xoff_o, 0);
    tick(); tick();
    rst_in = 1'b1;
    tick();

    // Full word, all groups: four consecutive bytes.
    send_word(32'hDDCCBBAA, 4'hF);
    wait_idle(n);
    chk("full_word_cycles", n, 4);

    send_word(32'hDDCCBBAA, 4'b0101);
    wait_idle(n);
    chk("grp0101_cycles", n, 2);

    send_word(32'hDDCCBBAA, 4'b0000);
    chk("grp0_busy", busy_o, 0);
    chk("grp0_rdy", smpl_rdy_o, 1);
    tick();

    // ID coinciding with a sample strobe: ID wins, word is not taken.
    id_stb_i = 1'b1; smpl_i = 32'hDEADBEEF; grp_en_i = 4'hF; smpl_stb_i = 1'b1;
    push_id();
    @(negedge clk_i);
    chk("id_blocks_rdy", smpl_rdy_o, 0);
    tick();
    id_stb_i = 1'b0; smpl_stb_i = 1'b0;
    wait_idle(n);
    chk("id_cycles", n, 4);
    tick();

    // ID during a word: reply follows back-to-back.
    send_word(32'h04030201, 4'hF);
    id_stb_i = 1'b1;
    push_id();
    tick();
    id_stb_i = 1'b0;
    wait_idle(n);
    chk("word_then_id_cycles", n + 1, 8);
    tick();

    // Stall with XOFF: AA held, transfers, BB withheld until XON.
    tx_rdy_i = 1'b0;
    send_word(32'hDDCCBBAA, 4'hF);
    xoff_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_stb", tx_stb_o, 1);
      chk("stall_data", tx_data_o, 32'hAA);
      tick();
      if (i == 0) xoff_i = 1'b0;
    end
    tx_rdy_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("paused_stb", tx_stb_o, 0);
      chk("paused_xoff", xoff_o, 1);
      tick();
    end
    xon_i = 1'b1;
    tick();
    xon_i = 1'b0;
    @(negedge clk_i);
    chk("resume_stb", tx_stb_o, 1);
    chk("resume_data", tx_data_o, 32'hBB);
    wait_idle(n);
    xon_i = 1'b1; xoff_i = 1'b1;
    tick();
    xon_i = 1'b0; xoff_i = 1'b0;
    chk("xon_xoff_both", xoff_o, 1);
    xon_i = 1'b1;
    tick();
    xon_i = 1'b0;
    chk("xon_clears", xoff_o, 0);

    // Reset while BB is pending.
    send_word(32'hDDCCBBAA, 4'hF);
    tick();
    tx_rdy_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_stb", tx_stb_o, 1);
    chk("pre_rst_data", tx_data_o, 32'hBB);
    #1 rst_in = 1'b0;
    #1;
    chk("mid_rst_stb", tx_stb_o, 0);
    chk("mid_rst_data", tx_data_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_rdy", smpl_rdy_o, 1);
    chk("pre_rst_sb_left", sb_q.size(), 3);
    sb_q.delete();
    tick(); tick();
    rst_in = 1'b1;
    tx_rdy_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (tx_stb_o) cnt++;
      tick();
    end
    chk("post_rst_residual", cnt, 0);
    chk("post_rst_rdy", smpl_rdy_o, 1);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
